evo_pacer: RTL and testbench

- Upstream pacing/control stage for the Round evolution engine.
- Turns user controls (start, pause, single-step, speed) into the toggle-style `global_evo_en` that Round consumes; Round starts one generation on each level change.
- Watches Round's RAM write stream to detect generation completion, so a new generation is never requested while one is in flight.
- Maintains a generation counter plus overrun/timeout status for the display and LED logic.

---
 rtl/game_pkg.sv | 21 ++
 rtl/tick_divider.sv | 33 +++
 rtl/evo_pacer.sv | 148 ++++++++++++++
 tb/tb_evo_pacer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the Round evolution engine: grid defaults, the pacing
// FSM state encoding, and the last-RAM-word address helper.
package game_pkg;

  localparam int P_PARAM_M_DEF = 5;
  localparam int P_PARAM_N_DEF = 5;
  localparam int BLOCK_LEN_DEF = 1;
  localparam int WIDTH_DEF     = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    EVOLVING = 2'd2
  } state_t;

  // Address of the final RAM word Round writes in one generation.
  function automatic int last_pos(input int m, input int n, input int blk);
    return (m * n / blk) - 1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running period divider; tick is asserted while the count has reached
// period-1, so shrinking the period mid-count fires on the next cycle.
module tick_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] count;

  assign tick = enable & (count >= (period - W'(1)));

  // Count while enabled; wrap on tick, hold while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= {W{1'b0}};
    end else if (clear) begin
      count <= {W{1'b0}};
    end else if (tick) begin
      count <= {W{1'b0}};
    end else if (enable) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/evo_pacer.sv
// Pacing stage for Round: issues toggle-style generation requests, tracks
// completion from the RAM write stream, and keeps generation/error status.
module evo_pacer
  import game_pkg::*;
#(
  parameter int P_PARAM_M = P_PARAM_M_DEF,
  parameter int P_PARAM_N = P_PARAM_N_DEF,
  parameter int BLOCK_LEN = BLOCK_LEN_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int BASE_DIV  = 1000000,
  parameter int SPEED_W   = 3,
  parameter int GEN_W     = 16,
  parameter int TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 step,
  input  logic [SPEED_W-1:0]   speed,
  input  logic                 wden,
  input  logic [2*WIDTH-1:0]   round_write_pos,
  output logic                 global_evo_en,
  output logic                 busy,
  output logic                 gen_done,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int PERIOD_W = $clog2((2 ** SPEED_W) * BASE_DIV + 1);
  localparam int TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [2*WIDTH-1:0] LAST_POS =
    (2*WIDTH)'(last_pos(P_PARAM_M, P_PARAM_N, BLOCK_LEN));

  state_t              state, state_nx;
  logic                start_q;
  logic [TO_W-1:0]     tcnt, tcnt_nx;
  logic [PERIOD_W-1:0] period;
  logic                tick, div_clear, div_enable, start_edge, last_write;
  logic                evo_en_nx, busy_nx, done_nx, ovr_nx, to_nx;
  logic [GEN_W-1:0]    cnt_nx;

  assign period     = PERIOD_W'((PERIOD_W'(speed) + PERIOD_W'(1)) * PERIOD_W'(BASE_DIV));
  assign start_edge = start & ~start_q;
  assign last_write = wden & (round_write_pos == LAST_POS);
  assign div_enable = (state != IDLE) & ~pause;

  tick_divider #(.W(PERIOD_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .enable (div_enable),
    .clear  (div_clear),
    .period (period),
    .tick   (tick)
  );

  // Next-state and next-output logic; a start edge overrides everything.
  always_comb begin
    state_nx  = state;
    evo_en_nx = global_evo_en;
    busy_nx   = busy;
    done_nx   = 1'b0;
    cnt_nx    = gen_count;
    ovr_nx    = overrun;
    to_nx     = timeout_err;
    tcnt_nx   = tcnt;
    div_clear = 1'b0;
    if (start_edge) begin
      // Round clears its previous-enable copy on the same edge, so restart low.
      state_nx  = WAIT;
      evo_en_nx = 1'b0;
      busy_nx   = 1'b0;
      cnt_nx    = {GEN_W{1'b0}};
      ovr_nx    = 1'b0;
      to_nx     = 1'b0;
      tcnt_nx   = {TO_W{1'b0}};
      div_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nx = IDLE;
        end
        WAIT: begin
          if (tick || (pause && step)) begin
            state_nx  = EVOLVING;
            evo_en_nx = ~global_evo_en;
            busy_nx   = 1'b1;
            tcnt_nx   = {TO_W{1'b0}};
          end else begin
            state_nx = WAIT;
          end
        end
        EVOLVING: begin
          if (last_write) begin
            state_nx  = WAIT;
            busy_nx   = 1'b0;
            done_nx   = 1'b1;
            cnt_nx    = gen_count + GEN_W'(1);
            div_clear = 1'b1;
          end else begin
            if (tick || step) begin
              ovr_nx = 1'b1;
            end else begin
              ovr_nx = overrun;
            end
            if (tcnt >= TO_W'(TIMEOUT - 1)) begin
              state_nx = WAIT;
              busy_nx  = 1'b0;
              to_nx    = 1'b1;
            end else begin
              tcnt_nx = tcnt + TO_W'(1);
            end
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      tcnt          <= {TO_W{1'b0}};
      global_evo_en <= 1'b0;
      busy          <= 1'b0;
      gen_done      <= 1'b0;
      gen_count     <= {GEN_W{1'b0}};
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_nx;
      start_q       <= start;
      tcnt          <= tcnt_nx;
      global_evo_en <= evo_en_nx;
      busy          <= busy_nx;
      gen_done      <= done_nx;
      gen_count     <= cnt_nx;
      overrun       <= ovr_nx;
      timeout_err   <= to_nx;
    end
  end

endmodule

// File: tb/tb_evo_pacer.sv
// Directed self-checking bench for evo_pacer with BASE_DIV=4, TIMEOUT=10.
module tb_evo_pacer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pause;
  logic        step;
  logic [2:0]  speed;
  logic        wden;
  logic [23:0] round_write_pos;
  logic        global_evo_en;
  logic        busy;
  logic        gen_done;
  logic [15:0] gen_count;
  logic        overrun;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  evo_pacer #(
    .P_PARAM_M (5),
    .P_PARAM_N (5),
    .BLOCK_LEN (1),
    .WIDTH     (12),
    .BASE_DIV  (4),
    .SPEED_W   (3),
    .GEN_W     (16),
    .TIMEOUT   (10)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .pause           (pause),
    .step            (step),
    .speed           (speed),
    .wden            (wden),
    .round_write_pos (round_write_pos),
    .global_evo_en   (global_evo_en),
    .busy            (busy),
    .gen_done        (gen_done),
    .gen_count       (gen_count),
    .overrun         (overrun),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; pause = 1'b0; step = 1'b0; speed = 3'd0;
    wden = 1'b0; round_write_pos = 24'd0;
    #2;
    tests++; if (global_evo_en !== 1'b0) begin fails++; $display("FAIL reset_en: got %b want 0", global_evo_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (gen_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", gen_done); end
    tests++; if (gen_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", gen_count); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(10);
    tests++; if (global_evo_en !== 1'b0) begin fails++; $display("FAIL idle_en: got %b want 0", global_evo_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_start_tick;
    start = 1'b1;
    cyc(1);
    tests++; if (global_evo_en !== 1'b0) begin fails++; $display("FAIL start_en0: got %b want 0", global_evo_en); end
    cyc(3);
    tests++; if (global_evo_en !== 1'b0) begin fails++; $display("FAIL start_en3: got %b want 0", global_evo_en); end
    cyc(1);
    tests++; if (global_evo_en !== 1'b1) begin fails++; $display("FAIL start_en4: got %b want 1", global_evo_en); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL start_busy4: got %b want 1", busy); end
  endtask

  task automatic test_completion;
    wden = 1'b1; round_write_pos = 24'd24;
    cyc(1);
    tests++; if (gen_done !== 1'b1) begin fails++; $display("FAIL cmp_done: got %b want 1", gen_done); end
    tests++; if (gen_count !== 16'd1) begin fails++; $display("FAIL cmp_count: got %0d want 1", gen_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cmp_busy: got %b want 0", busy); end
    cyc(1);
    tests++; if (gen_done !== 1'b0) begin fails++; $display("FAIL cmp_done_pulse: got %b want 0", gen_done); end
    tests++; if (gen_count !== 16'd1) begin fails++; $display("FAIL cmp_count_once: got %0d want 1", gen_count); end
    wden = 1'b0;
    cyc(2);
    tests++; if (global_evo_en !== 1'b1) begin fails++; $display("FAIL cmp_en3: got %b want 1", global_evo_en); end
    cyc(1);
    tests++; if (global_evo_en !== 1'b0) begin fails++; $display("FAIL cmp_en4: got %b want 0", global_evo_en); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL cmp_busy4: got %b want 1", busy); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL cmp_overrun: got %b want 0", overrun); end
    wden = 1'b1;
    cyc(1);
    wden = 1'b0;
    tests++; if (gen_count !== 16'd2) begin fails++; $display("FAIL cmp_count2: got %0d want 2", gen_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cmp_busy2: got %b want 0", busy); end
  endtask

  task automatic test_pause_step;
    pause = 1'b1;
    cyc(5);
    tests++; if (global_evo_en !== 1'b0) begin fails++; $display("FAIL pause_hold_en: got %b want 0", global_evo_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL pause_hold_busy: got %b want 0", busy); end
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    tests++; if (global_evo_en !== 1'b1) begin fails++; $display("FAIL step_en: got %b want 1", global_evo_en); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL step_busy: got %b want 1", busy); end
    cyc(1);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL step_overrun: got %b want 1", overrun); end
    tests++; if (global_evo_en !== 1'b1) begin fails++; $display("FAIL step_no_toggle: got %b want 1", global_evo_en); end
    wden = 1'b1;
    cyc(1);
    wden = 1'b0;
    tests++; if (gen_count !== 16'd3) begin fails++; $display("FAIL step_count: got %0d want 3", gen_count); end
    tests++; if (gen_done !== 1'b1) begin fails++; $display("FAIL step_done: got %b want 1", gen_done); end
    cyc(6);
    tests++; if (global_evo_en !== 1'b1) begin fails++; $display("FAIL paused_no_tick: got %b want 1", global_evo_en); end
    pause = 1'b0; step = 1'b1;
    cyc(1);
    step = 1'b0; pause = 1'b1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL step_unpaused_ignored: got %b want 0", busy); end
  endtask

  task automatic test_timeout;
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    tests++; if (global_evo_en !== 1'b0) begin fails++; $display("FAIL to_en: got %b want 0", global_evo_en); end
    cyc(9);
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_early: got %b want 0", timeout_err); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL to_busy9: got %b want 1", busy); end
    cyc(1);
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_flag: got %b want 1", timeout_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL to_busy: got %b want 0", busy); end
    tests++; if (gen_count !== 16'd3) begin fails++; $display("FAIL to_count: got %0d want 3", gen_count); end
    pause = 1'b0;
    cyc(2);
    tests++; if (global_evo_en !== 1'b0) begin fails++; $display("FAIL to_retick_early: got %b want 0", global_evo_en); end
    cyc(1);
    tests++; if (global_evo_en !== 1'b1) begin fails++; $display("FAIL to_retick: got %b want 1", global_evo_en); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL to_retick_busy: got %b want 1", busy); end
  endtask

  task automatic test_restart;
    start = 1'b0;
    cyc(1);
    tests++; if (global_evo_en !== 1'b1) begin fails++; $display("FAIL rs_pre_en: got %b want 1", global_evo_en); end
    start = 1'b1; wden = 1'b1; round_write_pos = 24'd24;
    cyc(1);
    wden = 1'b0;
    tests++; if (global_evo_en !== 1'b0) begin fails++; $display("FAIL rs_en: got %b want 0", global_evo_en); end
    tests++; if (gen_count !== 16'd0) begin fails++; $display("FAIL rs_count: got %0d want 0", gen_count); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rs_overrun: got %b want 0", overrun); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rs_timeout: got %b want 0", timeout_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rs_busy: got %b want 0", busy); end
    tests++; if (gen_done !== 1'b0) begin fails++; $display("FAIL rs_done: got %b want 0", gen_done); end
    cyc(1);
    tests++; if (gen_done !== 1'b0) begin fails++; $display("FAIL rs_done_late: got %b want 0", gen_done); end
  endtask

  task automatic test_async_reset;
    cyc(3);
    tests++; if (global_evo_en !== 1'b1) begin fails++; $display("FAIL ar_pre_en: got %b want 1", global_evo_en); end
    wden = 1'b1;
    cyc(1);
    wden = 1'b0;
    tests++; if (gen_count !== 16'd1) begin fails++; $display("FAIL ar_pre_count: got %0d want 1", gen_count); end
    cyc(2);
    #3;
    rst = 1'b0;
    #1;
    tests++; if (global_evo_en !== 1'b0) begin fails++; $display("FAIL ar_en: got %b want 0", global_evo_en); end
    tests++; if (gen_count !== 16'd0) begin fails++; $display("FAIL ar_count: got %0d want 0", gen_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ar_busy: got %b want 0", busy); end
    tests++; if ({gen_done, overrun, timeout_err} !== 3'b000) begin fails++; $display("FAIL ar_flags: got %b want 000", {gen_done, overrun, timeout_err}); end
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(10);
    tests++; if ({global_evo_en, busy} !== 2'b00) begin fails++; $display("FAIL ar_idle: got %b want 00", {global_evo_en, busy}); end
    start = 1'b1;
    cyc(4);
    tests++; if (global_evo_en !== 1'b0) begin fails++; $display("FAIL ar_restart_early: got %b want 0", global_evo_en); end
    cyc(1);
    tests++; if ({global_evo_en, busy} !== 2'b11) begin fails++; $display("FAIL ar_restart: got %b want 11", {global_evo_en, busy}); end
  endtask

  initial begin
    test_reset();
    test_start_tick();
    test_completion();
    test_pause_step();
    test_timeout();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
